store_buffer: RTL and testbench

Posted-write store buffer between the MEM stage and the data memory. It accepts store requests (SW/SB/SH) from the pipeline and aligns data and byte-enable mask to the address byte offset. It queues up to DEPTH stores and drains them to memory over a req/ack handshake. It also stalls loads that hit a pending store's word, so the pipeline never waits on memory latency for stores and never reads stale data.

---
 rtl/store_buffer.sv | 176 +++++++++++++++++
 tb/tb_store_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns SW/SH/SB stores and queues them ahead of data memory.
// Latency: push at edge N raises mem_req in cycle N+1; with ack held high one entry retires per cycle.
// Backpressure: ready = count < DEPTH (registered, no ack->ready path); loads to a pending word stall.
//
// Ports:
//   sb_i_clk, sb_i_rst_n             clock, async active-low reset
//   sb_i_valid/opcode/addr/data      store candidate from MEM stage; sb_o_ready accepts it
//   sb_o_misalign                    one-cycle pulse after a misaligned store is dropped
//   sb_i_load_valid/load_addr        load probe; sb_o_load_stall holds the load off
//   sb_o_mem_req/addr/data/mask      head entry towards memory; sb_i_mem_ack pops it
//   sb_o_empty, sb_o_count           occupancy

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef STORE
`define STORE 6'h2B
`endif
`ifndef STORE_BYTE
`define STORE_BYTE 6'h28
`endif
`ifndef STORE_HALF
`define STORE_HALF 6'h29
`endif

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 32
) (
    input  logic                      sb_i_clk,
    input  logic                      sb_i_rst_n,
    input  logic                      sb_i_valid,
    input  logic [`OPCODE_WIDTH-1:0]  sb_i_opcode,
    input  logic [AWIDTH-1:0]         sb_i_addr,
    input  logic [`DWIDTH-1:0]        sb_i_data,
    output logic                      sb_o_ready,
    output logic                      sb_o_misalign,
    input  logic                      sb_i_load_valid,
    input  logic [AWIDTH-1:0]         sb_i_load_addr,
    output logic                      sb_o_load_stall,
    output logic                      sb_o_mem_req,
    output logic [AWIDTH-1:0]         sb_o_mem_addr,
    output logic [`DWIDTH-1:0]        sb_o_mem_data,
    output logic [3:0]                sb_o_mem_mask,
    input  logic                      sb_i_mem_ack,
    output logic                      sb_o_empty,
    output logic [$clog2(DEPTH):0]    sb_o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AWIDTH - 2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DEPTH-1:0]     ent_vld;
    logic [WW-1:0]        ent_addr [DEPTH];
    logic [3:0]           ent_mask [DEPTH];
    logic [`DWIDTH-1:0]   ent_data [DEPTH];

    logic                 is_store, aligned;
    logic [3:0]           al_mask;
    logic [`DWIDTH-1:0]   al_data;
    logic [1:0]           off;
    logic                 push, pop, hit;
    logic [1:0]           unused_load_off;

    assign off             = sb_i_addr[1:0];
    assign unused_load_off = sb_i_load_addr[1:0];

    // Lane replication: the mask selects which replicated byte/half memory takes.
    always_comb begin
        is_store = 1'b0;
        aligned  = 1'b0;
        al_mask  = 4'b0000;
        al_data  = sb_i_data;
        case (sb_i_opcode)
            `STORE: begin
                is_store = 1'b1;
                aligned  = (off == 2'b00);
                al_mask  = 4'b1111;
            end
            `STORE_HALF: begin
                is_store = 1'b1;
                aligned  = ~off[0];
                al_mask  = 4'b0011 << off;
                al_data  = {2{sb_i_data[15:0]}};
            end
            `STORE_BYTE: begin
                is_store = 1'b1;
                aligned  = 1'b1;
                al_mask  = 4'b0001 << off;
                al_data  = {4{sb_i_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign sb_o_ready   = (count < CW'(DEPTH));
    assign sb_o_empty   = (count == '0);
    assign sb_o_count   = count;
    assign sb_o_mem_req = (state == BUSY);

    assign push = sb_i_valid & sb_o_ready & is_store & aligned;
    assign pop  = sb_o_mem_req & sb_i_mem_ack;

    assign sb_o_mem_addr = {ent_addr[rd_ptr], 2'b00};
    assign sb_o_mem_data = ent_data[rd_ptr];
    assign sb_o_mem_mask = ent_mask[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push) state_nxt = BUSY;
            BUSY: if (pop && !push && count == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An entry being pushed this cycle already blocks a load to its word.
    always_comb begin
        hit = push && (sb_i_addr[AWIDTH-1:2] == sb_i_load_addr[AWIDTH-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_addr[i] == sb_i_load_addr[AWIDTH-1:2])
                hit = 1'b1;
        end
    end
    assign sb_o_load_stall = sb_i_load_valid & hit;

    always_ff @(posedge sb_i_clk or negedge sb_i_rst_n) begin
        if (!sb_i_rst_n) begin
            state         <= IDLE;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ent_vld       <= '0;
            sb_o_misalign <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            sb_o_misalign <= sb_i_valid & sb_o_ready & is_store & ~aligned;
            if (push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PW'(1);
                ent_vld[rd_ptr] <= 1'b0;
            end
        end
    end

    // Payload needs no reset: ent_vld and count gate every use of it.
    always_ff @(posedge sb_i_clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= sb_i_addr[AWIDTH-1:2];
            ent_mask[wr_ptr] <= al_mask;
            ent_data[wr_ptr] <= al_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued at push time
// and compared in order as the DUT retires them; literal checks cover reset, misalign,
// full, load-stall and reset-mid-drain behaviour.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef STORE
`define STORE 6'h2B
`endif
`ifndef STORE_BYTE
`define STORE_BYTE 6'h28
`endif
`ifndef STORE_HALF
`define STORE_HALF 6'h29
`endif

module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam logic [5:0] OP_SW = `STORE;
    localparam logic [5:0] OP_SH = `STORE_HALF;
    localparam logic [5:0] OP_SB = `STORE_BYTE;
    localparam logic [5:0] OP_LW = 6'h23;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;

    logic        sb_i_clk = 1'b0;
    logic        sb_i_rst_n;
    logic        sb_i_valid;
    logic [5:0]  sb_i_opcode;
    logic [31:0] sb_i_addr;
    logic [31:0] sb_i_data;
    logic        sb_o_ready;
    logic        sb_o_misalign;
    logic        sb_i_load_valid;
    logic [31:0] sb_i_load_addr;
    logic        sb_o_load_stall;
    logic        sb_o_mem_req;
    logic [31:0] sb_o_mem_addr;
    logic [31:0] sb_o_mem_data;
    logic [3:0]  sb_o_mem_mask;
    logic        sb_i_mem_ack;
    logic        sb_o_empty;
    logic [2:0]  sb_o_count;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  exp_mis;
    bit  took;

    store_buffer #(.DEPTH(DEPTH), .AWIDTH(32)) dut (
        .sb_i_clk        (sb_i_clk),
        .sb_i_rst_n      (sb_i_rst_n),
        .sb_i_valid      (sb_i_valid),
        .sb_i_opcode     (sb_i_opcode),
        .sb_i_addr       (sb_i_addr),
        .sb_i_data       (sb_i_data),
        .sb_o_ready      (sb_o_ready),
        .sb_o_misalign   (sb_o_misalign),
        .sb_i_load_valid (sb_i_load_valid),
        .sb_i_load_addr  (sb_i_load_addr),
        .sb_o_load_stall (sb_o_load_stall),
        .sb_o_mem_req    (sb_o_mem_req),
        .sb_o_mem_addr   (sb_o_mem_addr),
        .sb_o_mem_data   (sb_o_mem_data),
        .sb_o_mem_mask   (sb_o_mem_mask),
        .sb_i_mem_ack    (sb_i_mem_ack),
        .sb_o_empty      (sb_o_empty),
        .sb_o_count      (sb_o_count)
    );

    always #5 sb_i_clk = ~sb_i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sb_i_clk);
        #1;
    endtask

    // Drive one store candidate and update the model for what the DUT should do with it.
    task automatic drive_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        bit         is_st, ok;
        logic [1:0] o;
        logic [3:0] m;
        logic [3:0] m_half, m_byte;
        logic [31:0] ad;
        wr_t        e;
        o      = a[1:0];
        m_half = 4'b0011;
        m_byte = 4'b0001;
        is_st  = 1'b1;
        ok     = 1'b1;
        m      = 4'b1111;
        ad     = d;
        if (op == OP_SW) begin
            ok = (o == 2'd0);
        end else if (op == OP_SH) begin
            ok = (o[0] == 1'b0);
            m  = m_half << o;
            ad = {d[15:0], d[15:0]};
        end else if (op == OP_SB) begin
            m  = m_byte << o;
            ad = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end else begin
            is_st = 1'b0;
        end
        exp_mis = is_st && !ok && (exp_q.size() < DEPTH);
        took    = is_st && ok && (exp_q.size() < DEPTH);
        if (took) begin
            e.addr = {a[31:2], 2'b00};
            e.mask = m;
            e.data = ad;
            exp_q.push_back(e);
        end
        sb_i_valid  = 1'b1;
        sb_i_opcode = op;
        sb_i_addr   = a;
        sb_i_data   = d;
    endtask

    task automatic finish_store;
        tick();
        sb_i_valid = 1'b0;
        chk("misalign", {63'd0, sb_o_misalign}, {63'd0, exp_mis});
    endtask

    task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        drive_store(op, a, d);
        finish_store();
    endtask

    // Retirement monitor: compare each accepted write against the scoreboard head.
    always @(negedge sb_i_clk) begin
        if (sb_i_rst_n && sb_o_mem_req && sb_i_mem_ack) begin
            chk("q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {32'd0, sb_o_mem_addr}, {32'd0, e.addr});
                chk("wr_mask", {60'd0, sb_o_mem_mask}, {60'd0, e.mask});
                chk("wr_data", {32'd0, sb_o_mem_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        sb_i_rst_n      = 1'b0;
        sb_i_valid      = 1'b0;
        sb_i_opcode     = '0;
        sb_i_addr       = '0;
        sb_i_data       = '0;
        sb_i_load_valid = 1'b1;
        sb_i_load_addr  = 32'h0000_0100;
        sb_i_mem_ack    = 1'b1;
        #2;
        // Reset state
        chk("rst_req",   {63'd0, sb_o_mem_req},    64'd0);
        chk("rst_ready", {63'd0, sb_o_ready},      64'd1);
        chk("rst_empty", {63'd0, sb_o_empty},      64'd1);
        chk("rst_count", {61'd0, sb_o_count},      64'd0);
        chk("rst_mis",   {63'd0, sb_o_misalign},   64'd0);
        chk("rst_stall", {63'd0, sb_o_load_stall}, 64'd0);
        sb_i_load_valid = 1'b0;
        #10 sb_i_rst_n = 1'b1;
        tick();

        // SW with ack tied high
        do_store(OP_SW, 32'h100, 32'hDEAD_BEEF);
        chk("sw_req",  {63'd0, sb_o_mem_req},  64'd1);
        chk("sw_addr", {32'd0, sb_o_mem_addr}, 64'h100);
        chk("sw_mask", {60'd0, sb_o_mem_mask}, 64'hF);
        chk("sw_data", {32'd0, sb_o_mem_data}, 64'hDEAD_BEEF);
        tick();
        chk("sw_empty", {63'd0, sb_o_empty},   64'd1);
        chk("sw_idle",  {63'd0, sb_o_mem_req}, 64'd0);

        // SB then SH lane alignment
        do_store(OP_SB, 32'h203, 32'h1234_5678);
        chk("sb_mask", {60'd0, sb_o_mem_mask}, 64'h8);
        chk("sb_data", {32'd0, sb_o_mem_data}, 64'h7878_7878);
        chk("sb_addr", {32'd0, sb_o_mem_addr}, 64'h200);
        do_store(OP_SH, 32'h202, 32'hABCD_1234);
        chk("sh_mask", {60'd0, sb_o_mem_mask}, 64'hC);
        chk("sh_data", {32'd0, sb_o_mem_data}, 64'h1234_1234);
        tick();
        chk("sbsh_empty", {63'd0, sb_o_empty}, 64'd1);

        // Misaligned stores and a non-store opcode
        do_store(OP_SW, 32'h102, 32'h1111_1111);
        chk("mis_sw_count", {61'd0, sb_o_count}, 64'd0);
        tick();
        chk("mis_sw_once", {63'd0, sb_o_misalign}, 64'd0);
        do_store(OP_SH, 32'h101, 32'h2222_2222);
        chk("mis_sh_count", {61'd0, sb_o_count}, 64'd0);
        tick();
        chk("mis_sh_once", {63'd0, sb_o_misalign}, 64'd0);
        do_store(OP_LW, 32'h102, 32'h3333_3333);
        chk("nonstore_count", {61'd0, sb_o_count}, 64'd0);

        // Fill to full with ack low, then drain in order
        sb_i_mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            do_store(OP_SW, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        chk("full_count", {61'd0, sb_o_count}, 64'd4);
        chk("full_ready", {63'd0, sb_o_ready}, 64'd0);
        do_store(OP_SW, 32'h410, 32'hBAD0_0005);
        chk("full_reject", {61'd0, sb_o_count}, 64'd4);
        sb_i_mem_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_req", {63'd0, sb_o_mem_req}, 64'd1);
            chk("drain_cnt", {61'd0, sb_o_count}, 64'(DEPTH - i));
            tick();
        end
        chk("drain_empty", {63'd0, sb_o_empty}, 64'd1);
        // Pointers wrap; push and pop overlap with ack high
        for (int i = 0; i < 3; i++) begin
            do_store(OP_SB, 32'h600 + 32'(i), 32'h0000_00C0 + 32'(i));
            chk("wrap_cnt", {61'd0, sb_o_count}, 64'(exp_q.size()));
        end
        tick();
        tick();
        chk("wrap_empty", {63'd0, sb_o_empty}, 64'd1);

        // Load stall against pending and in-flight entries
        sb_i_mem_ack    = 1'b0;
        sb_i_load_valid = 1'b1;
        sb_i_load_addr  = 32'h300;
        drive_store(OP_SW, 32'h300, 32'h5555_AAAA);
        #1;
        chk("stall_push", {63'd0, sb_o_load_stall}, 64'd1);
        finish_store();
        sb_i_load_addr = 32'h302;
        #1;
        chk("stall_hit", {63'd0, sb_o_load_stall}, 64'd1);
        sb_i_load_addr = 32'h304;
        #1;
        chk("stall_miss", {63'd0, sb_o_load_stall}, 64'd0);
        sb_i_load_addr = 32'h302;
        sb_i_mem_ack   = 1'b1;
        #1;
        chk("stall_ack_cyc", {63'd0, sb_o_load_stall}, 64'd1);
        tick();
        chk("stall_clear", {63'd0, sb_o_load_stall}, 64'd0);
        sb_i_load_valid = 1'b0;

        // Reset mid-drain
        sb_i_mem_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            do_store(OP_SW, 32'h500 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        chk("pre_rst_cnt", {61'd0, sb_o_count},   64'd3);
        chk("pre_rst_req", {63'd0, sb_o_mem_req}, 64'd1);
        #3;
        exp_q.delete();
        sb_i_rst_n = 1'b0;
        #1;
        chk("rst_mid_req",   {63'd0, sb_o_mem_req}, 64'd0);
        chk("rst_mid_count", {61'd0, sb_o_count},   64'd0);
        sb_i_load_valid = 1'b1;
        sb_i_load_addr  = 32'h500;
        #1;
        chk("rst_mid_stall", {63'd0, sb_o_load_stall}, 64'd0);
        sb_i_load_valid = 1'b0;
        #2 sb_i_rst_n = 1'b1;
        tick();
        chk("post_rst_empty", {63'd0, sb_o_empty},   64'd1);
        chk("post_rst_ready", {63'd0, sb_o_ready},   64'd1);
        chk("post_rst_req",   {63'd0, sb_o_mem_req}, 64'd0);

        chk("drain_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
